// File: rtl/aximm_test0_hls_deadlock_report_unit.sv
// rtl/aximm_test0_hls_deadlock_report_unit.sv - deadlock origin selection, token trace and report handshake
module aximm_test0_hls_deadlock_report_unit #(
  parameter int PROC_NUM      = 4,
  parameter int TS_WIDTH      = 32,
  parameter int TOKEN_TIMEOUT = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_seen_vec,
  input  logic                clr,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                dl_flag,
  output logic                rpt_vld,
  input  logic                rpt_rdy,
  output logic [PROC_NUM-1:0] rpt_proc,
  output logic [PROC_NUM-1:0] rpt_chain,
  output logic [TS_WIDTH-1:0] rpt_ts,
  output logic                rpt_timeout
);

  localparam int TMR_W = $clog2(TOKEN_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TOKEN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ORIGIN,
    ST_TRACE,
    ST_REPORT,
    ST_HALT
  } state_t;

  state_t              state;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TMR_W-1:0]    timer;
  logic [PROC_NUM-1:0] sel_oh;
  logic [PROC_NUM-1:0] lowest_oh;
  logic                return_hit;
  logic                timeout_hit;

  // Isolate the lowest set detect bit: x & -x keeps only the least significant one.
  assign lowest_oh   = dl_detect_vec & (~dl_detect_vec + PROC_NUM'(1));
  // The token has come home when the origin both sees it and still reports deadlock.
  assign return_hit  = |(token_seen_vec & dl_detect_vec & sel_oh);
  assign timeout_hit = (timer == TMR_LAST);

  // Free-running timestamp; software clear deliberately does not touch it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
    end
  end

  // Report FSM with registered outputs; clr overrides every state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      sel_oh      <= '0;
      origin_vec  <= '0;
      token_clear <= 1'b0;
      dl_flag     <= 1'b0;
      rpt_vld     <= 1'b0;
      rpt_proc    <= '0;
      rpt_chain   <= '0;
      rpt_ts      <= '0;
      rpt_timeout <= 1'b0;
    end else if (clr) begin
      state       <= ST_IDLE;
      timer       <= '0;
      sel_oh      <= '0;
      origin_vec  <= '0;
      token_clear <= 1'b0;
      dl_flag     <= 1'b0;
      rpt_vld     <= 1'b0;
      rpt_proc    <= '0;
      rpt_chain   <= '0;
      rpt_ts      <= '0;
      rpt_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|dl_detect_vec) begin
            sel_oh     <= lowest_oh;
            rpt_proc   <= lowest_oh;
            rpt_ts     <= ts_cnt;
            dl_flag    <= 1'b1;
            origin_vec <= lowest_oh;
            state      <= ST_ORIGIN;
          end
        end
        ST_ORIGIN: begin
          // Token activity seen during the origin strobe is not yet part of the trace.
          origin_vec <= '0;
          rpt_chain  <= sel_oh;
          timer      <= '0;
          state      <= ST_TRACE;
        end
        ST_TRACE: begin
          rpt_chain <= rpt_chain | token_seen_vec;
          timer     <= timer + TMR_W'(1);
          if (return_hit || timeout_hit) begin
            token_clear <= 1'b1;
            rpt_timeout <= ~return_hit;
            rpt_vld     <= 1'b1;
            state       <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          token_clear <= 1'b0;
          if (rpt_rdy) begin
            rpt_vld <= 1'b0;
            state   <= ST_HALT;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aximm_test0_hls_deadlock_report_unit.sv
// tb/tb_aximm_test0_hls_deadlock_report_unit.sv - directed self-checking bench for the deadlock report unit
module tb_aximm_test0_hls_deadlock_report_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  dl_detect_vec = '0;
  logic [3:0]  token_seen_vec = '0;
  logic        clr = 1'b0;
  logic [3:0]  origin_vec;
  logic        token_clear;
  logic        dl_flag;
  logic        rpt_vld;
  logic        rpt_rdy = 1'b0;
  logic [3:0]  rpt_proc;
  logic [3:0]  rpt_chain;
  logic [31:0] rpt_ts;
  logic        rpt_timeout;

  int checks = 0;
  int errors = 0;

  aximm_test0_hls_deadlock_report_unit #(
    .PROC_NUM(4),
    .TS_WIDTH(32),
    .TOKEN_TIMEOUT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dl_detect_vec(dl_detect_vec),
    .token_seen_vec(token_seen_vec),
    .clr(clr),
    .origin_vec(origin_vec),
    .token_clear(token_clear),
    .dl_flag(dl_flag),
    .rpt_vld(rpt_vld),
    .rpt_rdy(rpt_rdy),
    .rpt_proc(rpt_proc),
    .rpt_chain(rpt_chain),
    .rpt_ts(rpt_ts),
    .rpt_timeout(rpt_timeout)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++; if (origin_vec !== 4'b0000) begin errors++; $display("FAIL reset_origin: got %b expected 0000", origin_vec); end
    checks++; if (token_clear !== 1'b0) begin errors++; $display("FAIL reset_token_clear: got %b expected 0", token_clear); end
    checks++; if (dl_flag !== 1'b0) begin errors++; $display("FAIL reset_dl_flag: got %b expected 0", dl_flag); end
    checks++; if (rpt_vld !== 1'b0) begin errors++; $display("FAIL reset_rpt_vld: got %b expected 0", rpt_vld); end
    checks++; if ({rpt_proc, rpt_chain, rpt_timeout} !== 9'd0) begin errors++; $display("FAIL reset_rpt: got %b/%b/%b expected 0", rpt_proc, rpt_chain, rpt_timeout); end
    checks++; if (rpt_ts !== 32'd0) begin errors++; $display("FAIL reset_rpt_ts: got %0d expected 0", rpt_ts); end
    step();
    reset = 1'b1;
  endtask

  // Detection at ts_cnt=10, then trace 0100, 1000 and token return on process 1.
  task automatic test_origin_and_return();
    rpt_rdy = 1'b1;
    for (int i = 0; i < 10; i++) step();
    dl_detect_vec = 4'b0110;
    step();
    checks++; if (origin_vec !== 4'b0010) begin errors++; $display("FAIL origin_vec: got %b expected 0010", origin_vec); end
    checks++; if (rpt_proc !== 4'b0010) begin errors++; $display("FAIL origin_rpt_proc: got %b expected 0010", rpt_proc); end
    checks++; if (rpt_ts !== 32'd10) begin errors++; $display("FAIL origin_rpt_ts: got %0d expected 10", rpt_ts); end
    checks++; if (dl_flag !== 1'b1) begin errors++; $display("FAIL origin_dl_flag: got %b expected 1", dl_flag); end
    dl_detect_vec = 4'b0001;
    token_seen_vec = 4'b0001;
    step();
    checks++; if (origin_vec !== 4'b0000) begin errors++; $display("FAIL origin_one_cycle: got %b expected 0000", origin_vec); end
    checks++; if (rpt_chain !== 4'b0010) begin errors++; $display("FAIL origin_chain: got %b expected 0010", rpt_chain); end
    dl_detect_vec = 4'b0000;
    token_seen_vec = 4'b0100;
    step();
    token_seen_vec = 4'b1000;
    step();
    checks++; if (rpt_chain !== 4'b1110) begin errors++; $display("FAIL trace_chain: got %b expected 1110", rpt_chain); end
    checks++; if (token_clear !== 1'b0 || rpt_vld !== 1'b0) begin errors++; $display("FAIL trace_early_report: got tc=%b vld=%b expected 0/0", token_clear, rpt_vld); end
    token_seen_vec = 4'b0010;
    dl_detect_vec = 4'b0010;
    step();
    rpt_rdy = 1'b0;
    token_seen_vec = 4'b0000;
    dl_detect_vec = 4'b0000;
    checks++; if (token_clear !== 1'b1) begin errors++; $display("FAIL return_token_clear: got %b expected 1", token_clear); end
    checks++; if (rpt_vld !== 1'b1) begin errors++; $display("FAIL return_rpt_vld: got %b expected 1", rpt_vld); end
    checks++; if (rpt_chain !== 4'b1110) begin errors++; $display("FAIL return_chain: got %b expected 1110", rpt_chain); end
    checks++; if (rpt_timeout !== 1'b0) begin errors++; $display("FAIL return_timeout: got %b expected 0", rpt_timeout); end
    checks++; if (rpt_proc !== 4'b0010) begin errors++; $display("FAIL return_proc: got %b expected 0010", rpt_proc); end
  endtask

  // rpt_rdy low for five REPORT cycles, high on the sixth; HALT then ignores inputs.
  task automatic test_report_handshake();
    for (int i = 2; i <= 6; i++) begin
      step();
      checks++; if (rpt_vld !== 1'b1) begin errors++; $display("FAIL hold_vld cycle %0d: got %b expected 1", i, rpt_vld); end
      checks++; if (token_clear !== 1'b0) begin errors++; $display("FAIL hold_token_clear cycle %0d: got %b expected 0", i, token_clear); end
      checks++; if ({rpt_proc, rpt_chain, rpt_timeout} !== 9'b0010_1110_0 || rpt_ts !== 32'd10) begin
        errors++; $display("FAIL hold_payload cycle %0d: got %b/%b/%b/%0d expected 0010/1110/0/10", i, rpt_proc, rpt_chain, rpt_timeout, rpt_ts);
      end
    end
    rpt_rdy = 1'b1;
    step();
    rpt_rdy = 1'b0;
    checks++; if (rpt_vld !== 1'b0) begin errors++; $display("FAIL accept_vld: got %b expected 0", rpt_vld); end
    dl_detect_vec = 4'b1111;
    token_seen_vec = 4'b1111;
    for (int i = 0; i < 3; i++) step();
    checks++; if (origin_vec !== 4'b0000 || token_clear !== 1'b0 || rpt_vld !== 1'b0) begin
      errors++; $display("FAIL halt_outputs: got o=%b tc=%b vld=%b expected 0000/0/0", origin_vec, token_clear, rpt_vld);
    end
    checks++; if (dl_flag !== 1'b1) begin errors++; $display("FAIL halt_dl_flag: got %b expected 1", dl_flag); end
    checks++; if ({rpt_proc, rpt_chain, rpt_timeout} !== 9'b0010_1110_0 || rpt_ts !== 32'd10) begin
      errors++; $display("FAIL halt_payload: got %b/%b/%b/%0d expected 0010/1110/0/10", rpt_proc, rpt_chain, rpt_timeout, rpt_ts);
    end
  endtask

  // clr from HALT, new detection on process 3, then trace until timeout.
  task automatic test_clear_and_timeout();
    clr = 1'b1;
    step();
    clr = 1'b0;
    dl_detect_vec = 4'b0000;
    token_seen_vec = 4'b0000;
    checks++; if (dl_flag !== 1'b0) begin errors++; $display("FAIL clear_dl_flag: got %b expected 0", dl_flag); end
    checks++; if ({rpt_proc, rpt_chain, rpt_timeout, rpt_vld} !== 10'd0 || rpt_ts !== 32'd0) begin
      errors++; $display("FAIL clear_rpt: got %b/%b/%b/%b/%0d expected zeros", rpt_proc, rpt_chain, rpt_timeout, rpt_vld, rpt_ts);
    end
    dl_detect_vec = 4'b1000;
    step();
    dl_detect_vec = 4'b0000;
    checks++; if (origin_vec !== 4'b1000) begin errors++; $display("FAIL clear_origin: got %b expected 1000", origin_vec); end
    step();
    token_seen_vec = 4'b0100;
    for (int i = 1; i <= 8; i++) begin
      step();
      token_seen_vec = 4'b0000;
      if (i < 8) begin
        checks++; if (token_clear !== 1'b0) begin errors++; $display("FAIL timeout_early cycle %0d: got %b expected 0", i, token_clear); end
      end
    end
    checks++; if (token_clear !== 1'b1) begin errors++; $display("FAIL timeout_token_clear: got %b expected 1", token_clear); end
    checks++; if (rpt_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", rpt_timeout); end
    checks++; if (rpt_chain !== 4'b1100) begin errors++; $display("FAIL timeout_chain: got %b expected 1100", rpt_chain); end
    rpt_rdy = 1'b1;
    step();
    rpt_rdy = 1'b0;
    checks++; if (token_clear !== 1'b0 || rpt_vld !== 1'b0) begin errors++; $display("FAIL timeout_accept: got tc=%b vld=%b expected 0/0", token_clear, rpt_vld); end
  endtask

  // Return and timeout in the same cycle: return must win.
  task automatic test_return_at_timeout();
    clr = 1'b1;
    step();
    clr = 1'b0;
    dl_detect_vec = 4'b0001;
    step();
    dl_detect_vec = 4'b0000;
    step();
    for (int i = 0; i < 7; i++) step();
    token_seen_vec = 4'b0001;
    dl_detect_vec = 4'b0001;
    step();
    token_seen_vec = 4'b0000;
    dl_detect_vec = 4'b0000;
    checks++; if (token_clear !== 1'b1) begin errors++; $display("FAIL tie_token_clear: got %b expected 1", token_clear); end
    checks++; if (rpt_timeout !== 1'b0) begin errors++; $display("FAIL tie_timeout: got %b expected 0", rpt_timeout); end
    checks++; if (rpt_proc !== 4'b0001) begin errors++; $display("FAIL tie_proc: got %b expected 0001", rpt_proc); end
  endtask

  // Asynchronous reset in the middle of a trace.
  task automatic test_reset_mid_trace();
    clr = 1'b1;
    step();
    clr = 1'b0;
    dl_detect_vec = 4'b0100;
    step();
    dl_detect_vec = 4'b0000;
    step();
    step();
    token_seen_vec = 4'b0100;
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({origin_vec, token_clear, dl_flag, rpt_vld, rpt_proc, rpt_chain, rpt_timeout} !== 16'd0 || rpt_ts !== 32'd0) begin
      errors++; $display("FAIL async_reset: got o=%b tc=%b f=%b v=%b p=%b c=%b to=%b ts=%0d expected zeros", origin_vec, token_clear, dl_flag, rpt_vld, rpt_proc, rpt_chain, rpt_timeout, rpt_ts);
    end
    token_seen_vec = 4'b0000;
    step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if (token_clear !== 1'b0 || rpt_vld !== 1'b0 || dl_flag !== 1'b0) begin
        errors++; $display("FAIL post_reset cycle %0d: got tc=%b vld=%b f=%b expected 0/0/0", i, token_clear, rpt_vld, dl_flag);
      end
    end
  endtask

  initial begin
    test_reset();
    test_origin_and_return();
    test_report_handshake();
    test_clear_and_timeout();
    test_return_at_timeout();
    test_reset_mid_trace();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aximm_test0_hls_deadlock_report_unit.md
AXIMM_TEST0_HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: aximm_test0_hls_deadlock_report_unit

Interface
REQ-001 Parameter PROC_NUM, default 4: number of dataflow processes monitored.
REQ-002 Parameter TS_WIDTH, default 32: timestamp counter width.
REQ-003 Parameter TOKEN_TIMEOUT, default 64: maximum TRACE cycles before forced termination.
REQ-004 clock  in  1  single clock; all state on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset; asserted when reset==0.
REQ-006 dl_detect_vec  in  PROC_NUM  bit p = dl_detect_out of process p's detect unit.
REQ-007 token_seen_vec  in  PROC_NUM  bit p = OR of process p's token_in_vec.
REQ-008 clr  in  1  software clear; returns block to IDLE.
REQ-009 origin_vec  out  PROC_NUM  one-hot origin strobe, bit p drives process p's origin input.
REQ-010 token_clear  out  1  broadcast to every detect unit's token_clear input.
REQ-011 dl_flag  out  1  sticky "deadlock detected".
REQ-012 rpt_vld  out  1  report valid; rpt_rdy  in  1  report accepted.
REQ-013 rpt_proc  out  PROC_NUM  one-hot origin process of the report.
REQ-014 rpt_chain  out  PROC_NUM  processes visited by the token, including origin.
REQ-015 rpt_ts  out  TS_WIDTH  timestamp of first detection.
REQ-016 rpt_timeout  out  1  trace ended by timeout, not token return.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 ts_cnt SHALL increment every cycle from 0 after reset, wrap 2^TS_WIDTH-1 -> 0, and be unaffected by clr.
REQ-019 FSM states SHALL be IDLE, ORIGIN, TRACE, REPORT, HALT.
REQ-020 IDLE: when |dl_detect_vec, SHALL latch sel = lowest set index, rpt_ts = current ts_cnt, set dl_flag=1, go ORIGIN.
REQ-021 ORIGIN: origin_vec SHALL equal one-hot(sel) for exactly this one cycle; rpt_chain <= one-hot(sel); trace timer <= 0; go TRACE.
REQ-022 TRACE: each cycle rpt_chain |= token_seen_vec; timer increments by 1.
REQ-023 TRACE return condition: token_seen_vec[sel] & dl_detect_vec[sel] -> token_clear=1 for exactly one cycle (first REPORT cycle), rpt_timeout=0, go REPORT.
REQ-024 TRACE timeout: timer == TOKEN_TIMEOUT-1 with no return condition -> token_clear one-cycle pulse, rpt_timeout=1, go REPORT; if both hold in one cycle, return wins (rpt_timeout=0).
REQ-025 REPORT: rpt_vld=1 held with rpt_proc/rpt_chain/rpt_ts/rpt_timeout stable until the cycle rpt_rdy=1; then rpt_vld=0, go HALT.
REQ-026 rpt_rdy SHALL be ignored outside REPORT.
REQ-027 HALT: dl_detect_vec and token_seen_vec ignored; dl_flag stays 1; rpt_* hold last values.
REQ-028 clr=1 in any state SHALL take priority: next state IDLE, dl_flag=0, rpt_vld=0, origin_vec=0, token_clear=0, rpt_* = 0.
REQ-029 dl_detect_vec changes after latching in IDLE SHALL NOT alter sel.
REQ-030 token_seen_vec during ORIGIN SHALL be ignored.

Reset
REQ-031 reset==0 SHALL immediately force: state IDLE, origin_vec=0, token_clear=0, dl_flag=0, rpt_vld=0, rpt_proc=0, rpt_chain=0, rpt_ts=0, rpt_timeout=0, ts_cnt=0, timer=0.
REQ-032 reset mid-TRACE or mid-REPORT SHALL abandon the report without emitting token_clear.

Verification
REQ-033 dl_detect_vec=4'b0110 at ts_cnt=10 -> origin_vec=4'b0010 one cycle, rpt_proc=4'b0010, rpt_ts=10, dl_flag=1.
REQ-034 sel=1; token_seen_vec pulses 4'b0100, 4'b1000, then token_seen[1]&dl_detect[1] -> token_clear one cycle, rpt_chain=4'b1110, rpt_timeout=0.
REQ-035 TOKEN_TIMEOUT=8, no return -> token_clear 8 cycles after ORIGIN, rpt_timeout=1.
REQ-036 REPORT with rpt_rdy=0 for 5 cycles then 1 -> rpt_vld high 6 cycles, payload constant; HALT ignores new dl_detect_vec.
REQ-037 clr in HALT -> dl_flag=0, IDLE; next dl_detect_vec=4'b1000 -> origin_vec=4'b1000.
REQ-038 reset asserted mid-TRACE -> all outputs 0 asynchronously; no token_clear after release.
